// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes and optional iterative multiply/divide
//   Optional feature macro: ALU_MC_MULDIV_EN enables MUL/DIVU/REMU (BUSY state, counter, iteration datapath).
//   Without it, opcodes 1100-1110 return 0 at single-cycle latency and busy is tied low.
//   Ports:
//     clk       - clock, rising edge
//     rstn      - asynchronous active-low reset
//     in_valid  - operand/opcode valid
//     in_ready  - block can accept an operation (combinational)
//     alu_src1  - operand 1
//     alu_src2  - operand 2 (low SHW bits are the shift amount)
//     alu_func  - opcode
//     out_valid - alu_ans valid
//     out_ready - consumer accepts the result
//     alu_ans   - registered result
//     busy      - iterative multiply/divide in progress
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  input  logic [3:0]       alu_func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_ans,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic accept;
  logic [WIDTH-1:0] sc;
  logic [SHW-1:0] sh;
  assign sh = alu_src2[SHW-1:0];
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  always_comb begin
    sc = '0;
    case (alu_func)
      4'h0: sc = alu_src1 + alu_src2;
      4'h1: sc = alu_src1 - alu_src2;
      4'h2: sc = {{(WIDTH-1){1'b0}}, alu_src1 == alu_src2};
      4'h3: sc = {{(WIDTH-1){1'b0}}, alu_src1 < alu_src2};
      4'h4: sc = {{(WIDTH-1){1'b0}}, $signed(alu_src1) < $signed(alu_src2)};
      4'h5: sc = alu_src1 & alu_src2;
      4'h6: sc = alu_src1 | alu_src2;
      4'h7: sc = alu_src1 ^ alu_src2;
      4'h8: sc = alu_src1 << sh;
      4'h9: sc = alu_src1 >> sh;
      4'ha: sc = $unsigned($signed(alu_src1) >>> sh);
`ifdef ALU_MC_MULDIV_EN
      // only reached on divide by zero; nonzero divisors take the iterative path
      4'hd: sc = '1;
      4'he: sc = alu_src1;
`endif
      default: sc = '0;
    endcase
  end
`ifdef ALU_MC_MULDIV_EN
  // acc: product accumulator / partial remainder; opb: multiplicand / divisor; q: multiplier / quotient
  logic [WIDTH-1:0] acc, opb, q, acc_n, opb_n, q_n;
  logic [WIDTH:0] r_sh, diff;
  logic [SHW:0] cnt;
  logic is_mul, is_rem, long_op;
  assign long_op = alu_func == 4'hc || ((alu_func == 4'hd || alu_func == 4'he) && alu_src2 != '0);
  assign busy = state == BUSY;
  always_comb begin
    r_sh = {acc, q[WIDTH-1]};
    diff = r_sh - {1'b0, opb};
    acc_n = is_mul ? acc + (q[0] ? opb : '0) : (diff[WIDTH] ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0]);
    opb_n = is_mul ? opb << 1 : opb;
    q_n = is_mul ? q >> 1 : {q[WIDTH-2:0], ~diff[WIDTH]};
  end
`else
  assign busy = 1'b0;
`endif
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      alu_ans <= '0;
`ifdef ALU_MC_MULDIV_EN
      acc <= '0;
      opb <= '0;
      q <= '0;
      cnt <= '0;
      is_mul <= 1'b0;
      is_rem <= 1'b0;
`endif
    end
`ifdef ALU_MC_MULDIV_EN
    else if (state == BUSY) begin
      acc <= acc_n;
      opb <= opb_n;
      q <= q_n;
      cnt <= cnt - 1'b1;
      // last iteration lands in the same edge that enters DONE
      if (cnt == (SHW+1)'(1)) begin
        state <= DONE;
        alu_ans <= (is_mul || is_rem) ? acc_n : q_n;
      end
    end else if (accept && long_op) begin
      state <= BUSY;
      cnt <= (SHW+1)'(WIDTH);
      acc <= '0;
      is_mul <= alu_func == 4'hc;
      is_rem <= alu_func == 4'he;
      opb <= alu_func == 4'hc ? alu_src1 : alu_src2;
      q <= alu_func == 4'hc ? alu_src2 : alu_src1;
    end
`endif
    else if (accept) begin
      state <= DONE;
      alu_ans <= sc;
    end else if (state == DONE && out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc
module tb_alu_mc;
`ifdef ALU_MC_MULDIV_EN
  localparam int LONG = 32;
  localparam logic MD = 1'b1;
`else
  localparam int LONG = 0;
  localparam logic MD = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy;
  logic [31:0] alu_src1 = '0, alu_src2 = '0, alu_ans, held;
  logic [3:0] alu_func = '0;
  int n_chk = 0, n_fail = 0, lat, bcnt, rcnt, bad;
  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_func(alu_func),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ans(alu_ans), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_func = f;
    alu_src1 = a;
    alu_src2 = b;
  endtask
  task automatic single(input string tag, input logic [3:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    drive(f, a, b);
    step;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk(tag, alu_ans, exp);
  endtask
  task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    drive(f, a, b);
    step;
    in_valid = 1'b0;
    lat = 0;
    bcnt = 0;
    rcnt = 0;
    while (!out_valid && lat < 40) begin
      bcnt += int'(busy);
      rcnt += int'(in_ready);
      step;
      lat++;
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    step;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ans", alu_ans, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    step;
    rstn = 1'b1;
    step;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    // back-to-back single-cycle ops, out_ready held high
    single("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    single("lt_signed", 4'h4, 32'h8000_0000, 32'd1, 32'd1);
    single("ltu", 4'h3, 32'h8000_0000, 32'd1, 32'd0);
    single("sra", 4'ha, 32'h8000_0000, 32'h21, 32'hC000_0000);
    single("sub", 4'h1, 32'd5, 32'd7, 32'hFFFF_FFFE);
    single("eq_true", 4'h2, 32'd5, 32'd5, 32'd1);
    single("eq_false", 4'h2, 32'd5, 32'd6, 32'd0);
    single("lt_pos_neg", 4'h4, 32'd1, 32'h8000_0000, 32'd0);
    single("ltu_true", 4'h3, 32'd1, 32'h8000_0000, 32'd1);
    single("and", 4'h5, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    single("or", 4'h6, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
    single("xor", 4'h7, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    single("sll", 4'h8, 32'd1, 32'h24, 32'h10);
    single("srl", 4'h9, 32'h8000_0000, 32'd31, 32'd1);
    single("rsv_b_after_nz", 4'hb, 32'd3, 32'd4, 32'd0);
    single("srl_nz", 4'h9, 32'hF000_0000, 32'd4, 32'h0F00_0000);
    single("rsv_f", 4'hf, 32'd3, 32'd4, 32'd0);
    in_valid = 1'b0;
    step;
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    // iterative ops
    run_op(4'hc, 32'h0001_0003, 32'h0002_0005);
    chk("mul_lat", lat, LONG);
    chk("mul_busy_cycles", bcnt, LONG);
    chk("mul_in_ready_low", rcnt, 32'd0);
    chk("mul_busy_end", {31'd0, busy}, 32'd0);
    chk("mul_ans", alu_ans, MD ? 32'h000B_000F : 32'd0);
    run_op(4'hd, 32'd100, 32'd7);
    chk("divu_lat", lat, LONG);
    chk("divu_ans", alu_ans, MD ? 32'd14 : 32'd0);
    run_op(4'he, 32'd100, 32'd7);
    chk("remu_lat", lat, LONG);
    chk("remu_ans", alu_ans, MD ? 32'd2 : 32'd0);
    run_op(4'hd, 32'd5, 32'd0);
    chk("divu0_lat", lat, 32'd0);
    chk("divu0_ans", alu_ans, MD ? 32'hFFFF_FFFF : 32'd0);
    run_op(4'he, 32'd5, 32'd0);
    chk("remu0_lat", lat, 32'd0);
    chk("remu0_ans", alu_ans, MD ? 32'd5 : 32'd0);
    run_op(4'hc, 32'd3, 32'd5);
    chk("mul_3x5_lat", lat, LONG);
    chk("mul_3x5_ans", alu_ans, MD ? 32'd15 : 32'd0);
    step;
    // backpressure
    out_ready = 1'b0;
    drive(4'h7, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    step;
    chk("bp_xor_ans", alu_ans, 32'hAAAA_AAAA);
    held = alu_ans;
    drive(4'h0, 32'd2, 32'd3);
    bad = 0;
    repeat (5) begin
      step;
      if (alu_ans !== held || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    chk("bp_hold", bad, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_rise", {31'd0, in_ready}, 32'd1);
    step;
    chk("bp_accept_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_accept_ans", alu_ans, 32'd5);
    // reset mid-MUL
    drive(4'hc, 32'd3, 32'd5);
    step;
    in_valid = 1'b0;
    repeat (9) step;
    chk("mid_mul_busy", {31'd0, busy}, {31'd0, MD});
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ans", alu_ans, 32'd0);
    step;
    rstn = 1'b1;
    step;
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_idle_valid", {31'd0, out_valid}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
